// File: rtl/keypad_pkg.sv
// ============================================================================
// Module : keypad_pkg
// Brief  : Shared direction bit indices, direction key codes and helpers
//          for the 4x4 keypad motion front end.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  localparam int MOV_U = 3;
  localparam int MOV_D = 2;
  localparam int MOV_L = 1;
  localparam int MOV_R = 0;

  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_DOWN  = 4'd9;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] first_set(input logic [15:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module : key_debounce
// Brief  : Frame-rate debouncer for one key; stable toggles after
//          DEBOUNCE_FRAMES consecutive disagreeing frame samples.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic frame_tick,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [3:0] c_frames = 4'(DEBOUNCE_FRAMES);

  logic [3:0] r_cnt;
  logic       r_stable;
  logic [3:0] w_cnt_nxt;
  logic       w_toggle;

  assign w_cnt_nxt = r_cnt + 4'd1;
  assign w_toggle  = frame_tick && (raw != r_stable) && (w_cnt_nxt == c_frames);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt    <= 4'd0;
      r_stable <= 1'b0;
    end else if (frame_tick) begin
      if (raw == r_stable) begin
        r_cnt <= 4'd0;
      end else if (w_toggle) begin
        r_stable <= ~r_stable;
        r_cnt    <= 4'd0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = w_toggle && !r_stable;

endmodule

`default_nettype wire

// File: rtl/keypad_mov.sv
// ============================================================================
// Module : keypad_mov
// Brief  : 4x4 keypad column scanner with per-key debounce, direction
//          levels for the motion stage and a new-key-press event.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_mov
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] mov,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int                 c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_term  = c_cnt_w'(SCAN_DIV - 1);

  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_sync;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_col;
  logic [15:0]        r_raw;
  logic [3:0]         r_mov;
  logic               r_key_valid;
  logic [3:0]         r_key_code;

  logic               w_term;
  logic               w_frame_tick;
  logic [15:0]        w_raw_nxt;
  logic [15:0]        w_stable;
  logic [15:0]        w_rise;
  logic [3:0]         w_mov_nxt;

  assign w_term       = (r_cnt == c_term);
  assign w_frame_tick = w_term && (r_col == 2'd3);

  // Only the four keys of the active column are refreshed; 1 = pressed.
  always_comb begin
    w_raw_nxt = r_raw;
    for (int r = 0; r < 4; r++) begin
      w_raw_nxt[{2'(r), r_col}] = ~r_row_sync[r];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
      r_cnt      <= '0;
      r_col      <= 2'd0;
      r_raw      <= 16'd0;
    end else begin
      r_row_meta <= row_n;
      r_row_sync <= r_row_meta;
      if (w_term) begin
        r_cnt <= '0;
        r_col <= r_col + 2'd1;
        r_raw <= w_raw_nxt;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  generate
    for (genvar k = 0; k < 16; k++) begin : g_key
      key_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
      ) u_key_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .frame_tick(w_frame_tick),
        .raw       (r_raw[k]),
        .stable    (w_stable[k]),
        .rise      (w_rise[k])
      );
    end
  endgenerate

  // Opposing directions cancel so the motion stage never sees a conflict.
  always_comb begin
    w_mov_nxt        = 4'd0;
    w_mov_nxt[MOV_U] = w_stable[KEY_UP]    & ~w_stable[KEY_DOWN];
    w_mov_nxt[MOV_D] = w_stable[KEY_DOWN]  & ~w_stable[KEY_UP];
    w_mov_nxt[MOV_L] = w_stable[KEY_LEFT]  & ~w_stable[KEY_RIGHT];
    w_mov_nxt[MOV_R] = w_stable[KEY_RIGHT] & ~w_stable[KEY_LEFT];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mov       <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
    end else begin
      r_mov       <= w_mov_nxt;
      r_key_valid <= |w_rise;
      if (|w_rise) r_key_code <= first_set(w_rise);
    end
  end

  assign col_n     = ~(4'b0001 << r_col);
  assign mov       = r_mov;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

endmodule

`default_nettype wire

// File: tb/tb_keypad_mov.sv
// ============================================================================
// Module : tb_keypad_mov
// Brief  : Directed self-checking bench for keypad_mov with a keypad
//          matrix model (SCAN_DIV=8, DEBOUNCE_FRAMES=3, 32-cycle frame).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_mov;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  mov;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] keys;

  int total;
  int bad;
  int kv_cnt;

  keypad_mov #(
    .SCAN_DIV       (8),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .mov      (mov),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Pressed key at (row, col) pulls its row low while its column is driven.
  assign row_n[0] = ~|(keys[3:0]   & ~col_n);
  assign row_n[1] = ~|(keys[7:4]   & ~col_n);
  assign row_n[2] = ~|(keys[11:8]  & ~col_n);
  assign row_n[3] = ~|(keys[15:12] & ~col_n);

  always @(negedge sys_clk) begin
    if (sys_rst_n && key_valid === 1'b1) kv_cnt++;
  end

  task automatic run(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Reset released on a falling edge; the next rising edge is edge 1.
  task automatic do_reset(input logic [15:0] k);
    keys = k;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    kv_cnt = 0;
  endtask

  task automatic test_reset;
    keys = 16'd0;
    sys_rst_n = 1'b0;
    run(3);
    total++; if (col_n !== 4'b1110) begin bad++; $display("FAIL reset_col_n got=%b exp=1110", col_n); end
    total++; if (mov !== 4'b0000) begin bad++; $display("FAIL reset_mov got=%b exp=0000", mov); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_key_valid got=%b exp=0", key_valid); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_key_code got=%0d exp=0", key_code); end
  endtask

  task automatic test_col_scan;
    int          at  [10] = '{0, 7, 8, 15, 16, 23, 24, 31, 32, 40};
    logic [3:0]  exp [10] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011,
                              4'b1011, 4'b0111, 4'b0111, 4'b1110, 4'b1101};
    int          now;
    do_reset(16'd0);
    #1;
    now = 0;
    for (int i = 0; i < 10; i++) begin
      run(at[i] - now);
      now = at[i];
      total++;
      if (col_n !== exp[i]) begin
        bad++; $display("FAIL col_scan_edge%0d got=%b exp=%b", at[i], col_n, exp[i]);
      end
    end
  endtask

  task automatic test_right_hold;
    do_reset(16'h0040);
    run(95);
    total++; if (mov !== 4'b0000 || kv_cnt != 0) begin bad++; $display("FAIL right_early got mov=%b kv=%0d exp mov=0000 kv=0", mov, kv_cnt); end
    run(1);
    total++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin bad++; $display("FAIL right_valid got kv=%b code=%0d exp kv=1 code=6", key_valid, key_code); end
    total++; if (mov !== 4'b0000) begin bad++; $display("FAIL right_mov_lag got=%b exp=0000", mov); end
    run(1);
    total++; if (mov !== 4'b0001 || key_valid !== 1'b0) begin bad++; $display("FAIL right_mov got mov=%b kv=%b exp mov=0001 kv=0", mov, key_valid); end
    run(64);
    total++; if (kv_cnt != 1 || mov !== 4'b0001 || key_code !== 4'd6) begin bad++; $display("FAIL right_steady got kv=%0d mov=%b code=%0d exp kv=1 mov=0001 code=6", kv_cnt, mov, key_code); end
  endtask

  task automatic test_glitch;
    do_reset(16'h0010);
    run(64);
    keys = 16'd0;
    run(128);
    total++; if (mov !== 4'b0000) begin bad++; $display("FAIL glitch_mov got=%b exp=0000", mov); end
    total++; if (kv_cnt != 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", kv_cnt); end
  endtask

  task automatic test_left_right;
    do_reset(16'h0050);
    run(96);
    total++; if (key_valid !== 1'b1 || key_code !== 4'd4) begin bad++; $display("FAIL lr_valid got kv=%b code=%0d exp kv=1 code=4", key_valid, key_code); end
    run(100);
    total++; if (mov !== 4'b0000) begin bad++; $display("FAIL lr_mov got=%b exp=0000", mov); end
    total++; if (kv_cnt != 1) begin bad++; $display("FAIL lr_count got=%0d exp=1", kv_cnt); end
  endtask

  task automatic test_up_down;
    do_reset(16'h0002);
    run(64);
    keys = 16'h0202;
    run(33);
    total++; if (mov !== 4'b1000 || key_code !== 4'd1 || kv_cnt != 1) begin bad++; $display("FAIL ud_up got mov=%b code=%0d kv=%0d exp mov=1000 code=1 kv=1", mov, key_code, kv_cnt); end
    run(63);
    total++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin bad++; $display("FAIL ud_down_valid got kv=%b code=%0d exp kv=1 code=9", key_valid, key_code); end
    total++; if (mov !== 4'b1000) begin bad++; $display("FAIL ud_mov_lag got=%b exp=1000", mov); end
    run(1);
    total++; if (mov !== 4'b0000 || kv_cnt != 2) begin bad++; $display("FAIL ud_cancel got mov=%b kv=%0d exp mov=0000 kv=2", mov, kv_cnt); end
  endtask

  task automatic test_mid_reset;
    keys = 16'h0200;
    run(64);
    sys_rst_n = 1'b0;
    #1;
    total++; if (mov !== 4'b0000 || key_code !== 4'd0 || col_n !== 4'b1110 || key_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got mov=%b code=%0d col=%b kv=%b exp 0000/0/1110/0", mov, key_code, col_n, key_valid); end
    run(5);
    total++; if (mov !== 4'b0000 || key_code !== 4'd0 || col_n !== 4'b1110) begin bad++; $display("FAIL midrst_hold got mov=%b code=%0d col=%b exp 0000/0/1110", mov, key_code, col_n); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    kv_cnt = 0;
    run(96);
    total++; if (mov !== 4'b0000) begin bad++; $display("FAIL midrst_early got=%b exp=0000", mov); end
    total++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin bad++; $display("FAIL midrst_valid got kv=%b code=%0d exp kv=1 code=9", key_valid, key_code); end
    run(1);
    total++; if (mov !== 4'b0100) begin bad++; $display("FAIL midrst_down got=%b exp=0100", mov); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    kv_cnt = 0;
    keys = 16'd0;
    sys_rst_n = 1'b0;
    test_reset();
    test_col_scan();
    test_right_hold();
    test_glitch();
    test_left_right();
    test_up_down();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
